ysyx_23060184_trap_ctrl: RTL
============================

Name: ysyx_23060184_trap_ctrl

Overview:
Sequencer and write-port arbiter for the single-write-port machine-mode CSR file. It accepts trap (ecall) and mret requests from the writeback stage and serialises the required CSR writes (mepc, mcause, optionally mstatus) and reads (mtvec or mepc) over several cycles. It then issues a one-cycle PC redirect to the fetch stage. Ordinary CSR-instruction writes (csrrw/csrrs/csrrc) share the same write port and are granted only while the sequencer is idle.

Parameters:
DATA_WIDTH, 32, CSR data and PC width
ADDR_WIDTH, 10, CSR address width
MTVEC_ADDR, 10'h305, mtvec address
MEPC_ADDR, 10'h341, mepc address
MCAUSE_ADDR, 10'h342, mcause address
MSTATUS_ADDR, 10'h300, mstatus address

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  trap or mret request present
req_ready  out  1  request accepted this cycle when req_valid is also high
req_is_mret  in  1  1 = mret, 0 = ecall trap; sampled on accept
req_pc  in  DATA_WIDTH  PC of the trapping instruction; sampled on accept
req_cause  in  DATA_WIDTH  mcause value; sampled on accept
ins_wen  in  1  pipeline CSR-instruction write request
ins_waddr  in  ADDR_WIDTH  pipeline write address
ins_wdata  in  DATA_WIDTH  pipeline write data
ins_ready  out  1  pipeline write granted this cycle
csr_wen  out  1  CSR file write enable
csr_waddr  out  ADDR_WIDTH  CSR file write address
csr_wdata  out  DATA_WIDTH  CSR file write data
csr_raddr  out  ADDR_WIDTH  CSR file read address
csr_rdata  in  DATA_WIDTH  CSR file combinational read data
redirect_valid  out  1  one-cycle pulse: fetch jumps to redirect_pc
redirect_pc  out  DATA_WIDTH  redirect target (registered)
busy  out  1  high in every state other than IDLE

Behaviour:
- States:
  - IDLE: sole idle state.
  - W_EPC: csr_wen=1, waddr=MEPC_ADDR, wdata=latched pc.
  - W_CAUSE: csr_wen=1, waddr=MCAUSE_ADDR, wdata=latched cause.
  - W_MST: read-modify-write of mstatus. raddr=MSTATUS_ADDR; wdata is derived from csr_rdata in the same cycle.
  - RD_TGT: raddr=MTVEC_ADDR for a trap or MEPC_ADDR for mret. Latches redirect_pc from csr_rdata; for a trap, bits [1:0] are cleared (direct mode only).
  - REDIR: redirect_valid=1 for exactly one cycle, then IDLE.
- Transitions:
  - Trap: IDLE -> W_EPC -> W_CAUSE -> [W_MST] -> RD_TGT -> REDIR -> IDLE.
  - mret: IDLE -> [W_MST] -> RD_TGT -> REDIR -> IDLE.
- Latency, with accept at cycle T:
  - Trap: redirect_valid at T+4, or T+5 with the optional feature.
  - mret: redirect_valid at T+2, or T+3 with the optional feature.
- IDLE arbitration:
  - ins_ready=1 in IDLE.
  - If ins_wen=1, ins_* pass combinationally to csr_w*, and req_ready=0 that cycle (instruction write has priority; the request waits).
  - Otherwise req_ready=1.
  - No state other than IDLE grants: ins_ready=0 and req_ready=0 in every non-IDLE state.
- csr_wen=0 in IDLE when ins_wen=0, and in RD_TGT and REDIR.
- csr_raddr=MSTATUS_ADDR whenever unused (don't-care, but fixed for determinism).
- The request is held by the producer until accepted; inputs are ignored while busy.
- Back-to-back: a new request may be accepted in the first IDLE cycle after REDIR.
- Reset (synchronous, any state including mid-sequence):
  - Next state is IDLE; no CSR write is issued in the reset cycle.
  - redirect_valid=0, redirect_pc=0, busy=0, csr_wen=0.
  - Latched pc/cause/kind are cleared to 0.
  - A partially written sequence is not resumed.

Optional Feature:
- Macro: YSYX_23060184_TRAP_MSTATUS_EN.
- Defined: W_MST is present.
  - On a trap: MPIE(bit7) <= MIE(bit3), MIE <= 0, MPP[12:11] <= 2'b11.
  - On mret: MIE <= MPIE, MPIE <= 1, MPP <= 2'b11.
  - All other bits pass through from csr_rdata.
- Not defined: W_MST is skipped, mstatus is never read or written, and latencies are as quoted without the feature.

Test Plan:
- Reset then idle 5 cycles -> busy=0, redirect_valid=0, csr_wen=0, redirect_pc=0.
- Trap request, macro off (mtvec=0x80000103, pc=0x80000010, cause=11) accepted at T -> mepc write 0x80000010 at T+1; mcause write 11 at T+2; redirect_valid at T+4 with redirect_pc=0x80000100.
- mret, macro on (mepc=0x80000014, mstatus=0x00000080) -> mstatus write 0x00001888 at T+1; redirect 0x80000014 at T+3.
- Simultaneous ins_wen (0x305 <- 0x80000200) and req_valid in IDLE -> pipeline write first with req_ready=0; request accepted next cycle; trap redirects to 0x80000200.
- ins_wen asserted at W_CAUSE -> ins_ready=0 until IDLE; no pipeline write leaks onto csr_w* while busy.
- rst asserted at W_CAUSE -> IDLE next cycle, no mcause write, no redirect_valid; a fresh trap then completes normally.

Source files
------------

// File: rtl/ysyx_23060184_trap_ctrl.sv
// Trap/mret sequencer and single-write-port arbiter for the machine-mode CSR file.
// Optional mstatus read-modify-write step enabled by defining YSYX_23060184_TRAP_MSTATUS_EN.
module ysyx_23060184_trap_ctrl #(
  parameter int unsigned            DATA_WIDTH   = 32,
  parameter int unsigned            ADDR_WIDTH   = 10,
  parameter logic [ADDR_WIDTH-1:0]  MTVEC_ADDR   = 10'h305,
  parameter logic [ADDR_WIDTH-1:0]  MEPC_ADDR    = 10'h341,
  parameter logic [ADDR_WIDTH-1:0]  MCAUSE_ADDR  = 10'h342,
  parameter logic [ADDR_WIDTH-1:0]  MSTATUS_ADDR = 10'h300
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_mret,
  input  logic [DATA_WIDTH-1:0] req_pc,
  input  logic [DATA_WIDTH-1:0] req_cause,
  input  logic                  ins_wen,
  input  logic [ADDR_WIDTH-1:0] ins_waddr,
  input  logic [DATA_WIDTH-1:0] ins_wdata,
  output logic                  ins_ready,
  output logic                  csr_wen,
  output logic [ADDR_WIDTH-1:0] csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic [ADDR_WIDTH-1:0] csr_raddr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_EPC, S_W_CAUSE, S_W_MST, S_RD_TGT, S_REDIR
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] cause_q, cause_d;
  logic                  mret_q, mret_d;
  logic [DATA_WIDTH-1:0] rpc_q, rpc_d;
  logic                  wen_c, req_rdy_c, ins_rdy_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
      rpc_q   <= rpc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cause_d   = cause_q;
    mret_d    = mret_q;
    rpc_d     = rpc_q;
    wen_c     = 1'b0;
    csr_waddr = MSTATUS_ADDR;
    csr_wdata = '0;
    csr_raddr = MSTATUS_ADDR;
    req_rdy_c = 1'b0;
    ins_rdy_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        ins_rdy_c = 1'b1;
        if (ins_wen) begin
          wen_c     = 1'b1;
          csr_waddr = ins_waddr;
          csr_wdata = ins_wdata;
        end else begin
          req_rdy_c = 1'b1;
          if (req_valid) begin
            pc_d    = req_pc;
            cause_d = req_cause;
            mret_d  = req_is_mret;
`ifdef YSYX_23060184_TRAP_MSTATUS_EN
            state_d = req_is_mret ? S_W_MST : S_W_EPC;
`else
            state_d = req_is_mret ? S_RD_TGT : S_W_EPC;
`endif
          end
        end
      end
      S_W_EPC: begin
        wen_c     = 1'b1;
        csr_waddr = MEPC_ADDR;
        csr_wdata = pc_q;
        state_d   = S_W_CAUSE;
      end
      S_W_CAUSE: begin
        wen_c     = 1'b1;
        csr_waddr = MCAUSE_ADDR;
        csr_wdata = cause_q;
`ifdef YSYX_23060184_TRAP_MSTATUS_EN
        state_d   = S_W_MST;
`else
        state_d   = S_RD_TGT;
`endif
      end
`ifdef YSYX_23060184_TRAP_MSTATUS_EN
      // Read-modify-write in one cycle: CSR file read port is combinational.
      S_W_MST: begin
        wen_c     = 1'b1;
        csr_waddr = MSTATUS_ADDR;
        csr_raddr = MSTATUS_ADDR;
        csr_wdata = csr_rdata;
        csr_wdata[12:11] = 2'b11;
        if (mret_q) begin
          csr_wdata[3] = csr_rdata[7];
          csr_wdata[7] = 1'b1;
        end else begin
          csr_wdata[7] = csr_rdata[3];
          csr_wdata[3] = 1'b0;
        end
        state_d = S_RD_TGT;
      end
`endif
      S_RD_TGT: begin
        csr_raddr = mret_q ? MEPC_ADDR : MTVEC_ADDR;
        rpc_d     = mret_q ? csr_rdata : {csr_rdata[DATA_WIDTH-1:2], 2'b00};
        state_d   = S_REDIR;
      end
      S_REDIR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset cycle must not issue writes, grants or redirects even mid-sequence.
  assign csr_wen        = wen_c & ~rst;
  assign req_ready      = req_rdy_c & ~rst;
  assign ins_ready      = ins_rdy_c & ~rst;
  assign redirect_valid = (state_q == S_REDIR) & ~rst;
  assign busy           = (state_q != S_IDLE) & ~rst;
  assign redirect_pc    = rpc_q;

endmodule
